// File: rtl/pit_8254_pkg.sv
// Shared constants, types and helpers for the 8254 PIT bus front end.
package pit_8254_pkg;

    // I/O port offsets relative to 0x40
    localparam logic [1:0] PIT_PORT_CNT0 = 2'd0;
    localparam logic [1:0] PIT_PORT_CNT1 = 2'd1;
    localparam logic [1:0] PIT_PORT_CNT2 = 2'd2;
    localparam logic [1:0] PIT_PORT_CTRL = 2'd3;

    // Control word field positions
    localparam int unsigned CW_SC_MSB   = 7;
    localparam int unsigned CW_SC_LSB   = 6;
    localparam int unsigned CW_RW_MSB   = 5;
    localparam int unsigned CW_RW_LSB   = 4;
    localparam int unsigned CW_MODE_MSB = 3;
    localparam int unsigned CW_MODE_LSB = 1;
    localparam int unsigned CW_BCD_BIT  = 0;

    localparam logic [1:0] RW_LATCH    = 2'b00;
    localparam logic [1:0] SC_READBACK = 2'b11;

    // Read-back command bits (count/status enables are active-low)
    localparam int unsigned RB_NCOUNT_BIT  = 5;
    localparam int unsigned RB_NSTATUS_BIT = 4;
    localparam int unsigned RB_MASK_MSB    = 3;
    localparam int unsigned RB_MASK_LSB    = 1;

    // Value returned when the write-only control port is read
    localparam logic [7:0] PIT_CTRL_READ_DATA = 8'hFF;

    typedef enum logic [1:0] {
        RdIdle,
        RdStrobe,
        RdRespond
    } rd_state_e;

    typedef struct packed {
        logic [2:0] set_mode;
        logic [2:0] latch_count;
        logic [2:0] latch_status;
        logic [2:0] write;
        logic [2:0] read;
    } pit_strobes_t;

    // Channel index to one-hot strobe; index 3 selects nothing
    function automatic logic [2:0] chan_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        unique case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // round(pit_hz * 2^acc_w / clk_hz)
    function automatic longint unsigned pit_phase_inc(input longint unsigned clk_hz,
                                                      input longint unsigned pit_hz,
                                                      input int unsigned     acc_w);
        return ((pit_hz << acc_w) + (clk_hz >> 1)) / clk_hz;
    endfunction

endpackage

// File: rtl/pit_8254_clkgen.sv
// PIT input clock generator (fractional phase accumulator) and gate synchroniser.
module pit_8254_clkgen
    import pit_8254_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned PIT_FREQ_HZ = 1193182,
    parameter int unsigned ACC_W       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] gate_in,
    output logic       pit_clock,
    output logic [2:0] cnt_gate
);

    localparam longint unsigned INC_FULL =
        pit_phase_inc(64'(CLK_FREQ_HZ), 64'(PIT_FREQ_HZ), ACC_W);
    localparam logic [ACC_W-1:0] INC = INC_FULL[ACC_W-1:0];

    // Each pit_clock level must last at least one system clock
    if (2 * PIT_FREQ_HZ > CLK_FREQ_HZ) begin : g_freq_check
        $error("PIT_FREQ_HZ must not exceed half of CLK_FREQ_HZ");
    end

    logic [ACC_W-1:0] acc_q;
    logic             pit_clock_q;
    logic [2:0]       gate_meta_q;
    logic [2:0]       gate_sync_q;

    // Accumulator wraps modulo 2^ACC_W; its MSB is the divided clock
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            pit_clock_q <= 1'b0;
        end else begin
            acc_q       <= acc_q + INC;
            pit_clock_q <= acc_q[ACC_W-1];
        end
    end

    // Two-flop synchroniser for the asynchronous gate inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_meta_q <= '0;
            gate_sync_q <= '0;
        end else begin
            gate_meta_q <= gate_in;
            gate_sync_q <= gate_meta_q;
        end
    end

    assign pit_clock = pit_clock_q;
    assign cnt_gate  = gate_sync_q;

endmodule

// File: rtl/pit_8254_bus_if.sv
// Bus front end for the three 8254 counters: command decode, strobes, read data.
module pit_8254_bus_if
    import pit_8254_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned PIT_FREQ_HZ = 1193182,
    parameter int unsigned ACC_W       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic [1:0]  io_req_addr,
    input  logic        io_req_we,
    input  logic [7:0]  io_req_data,
    output logic        io_rsp_valid,
    output logic [7:0]  io_rsp_data,
    input  logic [2:0]  gate_in,
    output logic        pit_clock,
    output logic [2:0]  cnt_gate,
    output logic [7:0]  cnt_data_in,
    output logic [2:0]  cnt_set_control_mode,
    output logic [2:0]  cnt_latch_count,
    output logic [2:0]  cnt_latch_status,
    output logic [2:0]  cnt_write,
    output logic [2:0]  cnt_read,
    input  logic [23:0] cnt_data_out
);

    rd_state_e    state_q, state_d;
    logic [1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]   rsp_data_q, rsp_data_d;
    logic         rsp_valid_q, rsp_valid_d;
    pit_strobes_t strb_q, strb_d;
    logic [7:0]   data_in_q, data_in_d;
    logic [7:0]   rd_sel;
    logic         rd_busy;
    logic         req_accept;
    logic [1:0]   cw_sc;
    logic [1:0]   cw_rw;
    logic [2:0]   rb_mask;

    assign rd_busy      = (state_q != RdIdle);
    assign io_req_ready = ~reset & ~rd_busy;
    assign req_accept   = io_req_valid & io_req_ready;

    assign cw_sc   = io_req_data[CW_SC_MSB:CW_SC_LSB];
    assign cw_rw   = io_req_data[CW_RW_MSB:CW_RW_LSB];
    assign rb_mask = io_req_data[RB_MASK_MSB:RB_MASK_LSB];

    // Decode the accepted request into next-cycle strobes and the broadcast byte
    always_comb begin
        strb_d    = '0;
        data_in_d = data_in_q;
        if (req_accept) begin
            if (io_req_we) begin
                data_in_d = io_req_data;
                if (io_req_addr != PIT_PORT_CTRL) begin
                    strb_d.write = chan_onehot(io_req_addr);
                end else if (cw_sc != SC_READBACK) begin
                    if (cw_rw == RW_LATCH) begin
                        strb_d.latch_count = chan_onehot(cw_sc);
                    end else begin
                        strb_d.set_mode = chan_onehot(cw_sc);
                    end
                end else begin
                    strb_d.latch_count  = io_req_data[RB_NCOUNT_BIT]  ? 3'b000 : rb_mask;
                    strb_d.latch_status = io_req_data[RB_NSTATUS_BIT] ? 3'b000 : rb_mask;
                end
            end else begin
                strb_d.read = chan_onehot(io_req_addr);
            end
        end
    end

    // Select the addressed counter's output byte
    always_comb begin
        rd_sel = PIT_CTRL_READ_DATA;
        unique case (rd_addr_q)
            PIT_PORT_CNT0: rd_sel = cnt_data_out[7:0];
            PIT_PORT_CNT1: rd_sel = cnt_data_out[15:8];
            PIT_PORT_CNT2: rd_sel = cnt_data_out[23:16];
            default:       rd_sel = PIT_CTRL_READ_DATA;
        endcase
    end

    // Read sequencer: strobe cycle captures pre-update data, respond cycle pulses valid
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            RdIdle: begin
                if (req_accept && !io_req_we) begin
                    rd_addr_d = io_req_addr;
                    state_d   = RdStrobe;
                end
            end
            RdStrobe: begin
                rsp_data_d  = rd_sel;
                rsp_valid_d = 1'b1;
                state_d     = RdRespond;
            end
            RdRespond: begin
                state_d = RdIdle;
            end
            default: begin
                state_d = RdIdle;
            end
        endcase
    end

    // Bus-side state; reset discards any pending strobe or response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RdIdle;
            rd_addr_q   <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            strb_q      <= '0;
            data_in_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            strb_q      <= strb_d;
            data_in_q   <= data_in_d;
        end
    end

    assign io_rsp_valid         = rsp_valid_q;
    assign io_rsp_data          = rsp_data_q;
    assign cnt_data_in          = data_in_q;
    assign cnt_set_control_mode = strb_q.set_mode;
    assign cnt_latch_count      = strb_q.latch_count;
    assign cnt_latch_status     = strb_q.latch_status;
    assign cnt_write            = strb_q.write;
    assign cnt_read             = strb_q.read;

    pit_8254_clkgen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .PIT_FREQ_HZ (PIT_FREQ_HZ),
        .ACC_W       (ACC_W)
    ) u_clkgen (
        .clk       (clk),
        .reset     (reset),
        .gate_in   (gate_in),
        .pit_clock (pit_clock),
        .cnt_gate  (cnt_gate)
    );

endmodule

// File: tb/tb_pit_8254_bus_if.sv
// Directed self-checking bench for pit_8254_bus_if.
module tb_pit_8254_bus_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_req_valid;
    logic        io_req_ready;
    logic [1:0]  io_req_addr;
    logic        io_req_we;
    logic [7:0]  io_req_data;
    logic        io_rsp_valid;
    logic [7:0]  io_rsp_data;
    logic [2:0]  gate_in;
    logic        pit_clock;
    logic [2:0]  cnt_gate;
    logic [7:0]  cnt_data_in;
    logic [2:0]  cnt_set_control_mode;
    logic [2:0]  cnt_latch_count;
    logic [2:0]  cnt_latch_status;
    logic [2:0]  cnt_write;
    logic [2:0]  cnt_read;
    logic [23:0] cnt_data_out;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    pit_8254_bus_if dut (
        .clk                  (clk),
        .reset                (reset),
        .io_req_valid         (io_req_valid),
        .io_req_ready         (io_req_ready),
        .io_req_addr          (io_req_addr),
        .io_req_we            (io_req_we),
        .io_req_data          (io_req_data),
        .io_rsp_valid         (io_rsp_valid),
        .io_rsp_data          (io_rsp_data),
        .gate_in              (gate_in),
        .pit_clock            (pit_clock),
        .cnt_gate             (cnt_gate),
        .cnt_data_in          (cnt_data_in),
        .cnt_set_control_mode (cnt_set_control_mode),
        .cnt_latch_count      (cnt_latch_count),
        .cnt_latch_status     (cnt_latch_status),
        .cnt_write            (cnt_write),
        .cnt_read             (cnt_read),
        .cnt_data_out         (cnt_data_out)
    );

    // {set_mode, latch_count, latch_status, write, read}
    logic [14:0] strobes;
    assign strobes = {cnt_set_control_mode, cnt_latch_count, cnt_latch_status,
                      cnt_write, cnt_read};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  ctl_v [3];
    logic [14:0] ctl_e [3];
    int unsigned edges;
    logic        pit_prev;

    initial begin
        ctl_v = '{8'h40, 8'hC2, 8'hE6};
        ctl_e = '{{3'b000, 3'b010, 3'b000, 3'b000, 3'b000},
                  {3'b000, 3'b001, 3'b001, 3'b000, 3'b000},
                  {3'b000, 3'b000, 3'b011, 3'b000, 3'b000}};

        reset        = 1'b1;
        io_req_valid = 1'b0;
        io_req_addr  = 2'd0;
        io_req_we    = 1'b0;
        io_req_data  = 8'h00;
        gate_in      = 3'b000;
        cnt_data_out = {8'h5A, 8'h77, 8'h33};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, io_req_ready}, 32'd0);
        check("rst_strobes", {17'd0, strobes}, 32'd0);
        check("rst_rsp", {23'd0, io_rsp_valid, io_rsp_data}, 32'd0);
        check("rst_clk_gate", {28'd0, pit_clock, cnt_gate}, 32'd0);
        check("rst_data_in", {24'd0, cnt_data_in}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, io_req_ready}, 32'd1);

        // Mode-set control word
        @(negedge clk);
        io_req_valid = 1'b1; io_req_we = 1'b1; io_req_addr = 2'd3; io_req_data = 8'h34;
        @(negedge clk);
        io_req_valid = 1'b0;
        check("mode_strobes", {17'd0, strobes}, {17'd0, 15'b001_000_000_000_000});
        check("mode_data", {24'd0, cnt_data_in}, 32'h34);
        check("mode_no_rsp", {31'd0, io_rsp_valid}, 32'd0);
        @(negedge clk);
        check("mode_one_cycle", {17'd0, strobes}, 32'd0);

        // Back-to-back counter writes
        io_req_valid = 1'b1; io_req_we = 1'b1; io_req_addr = 2'd0; io_req_data = 8'h9C;
        @(negedge clk);
        check("b2b_ready", {31'd0, io_req_ready}, 32'd1);
        check("b2b_wr1", {17'd0, strobes}, {17'd0, 15'b000_000_000_001_000});
        check("b2b_data1", {24'd0, cnt_data_in}, 32'h9C);
        io_req_data = 8'h2E;
        @(negedge clk);
        io_req_valid = 1'b0;
        check("b2b_wr2", {17'd0, strobes}, {17'd0, 15'b000_000_000_001_000});
        check("b2b_data2", {24'd0, cnt_data_in}, 32'h2E);
        @(negedge clk);
        check("b2b_idle", {17'd0, strobes}, 32'd0);

        // Read counter 2; data must be the value seen during the strobe cycle
        io_req_valid = 1'b1; io_req_we = 1'b0; io_req_addr = 2'd2;
        @(negedge clk);
        io_req_valid = 1'b0;
        check("rd2_strobe", {17'd0, strobes}, {17'd0, 15'b000_000_000_000_100});
        check("rd2_busy1", {30'd0, io_req_ready, io_rsp_valid}, 32'd0);
        @(negedge clk);
        cnt_data_out[23:16] = 8'h12;
        check("rd2_rsp", {23'd0, io_rsp_valid, io_rsp_data}, {23'd0, 1'b1, 8'h5A});
        check("rd2_busy2", {31'd0, io_req_ready}, 32'd0);
        check("rd2_strobe_gone", {17'd0, strobes}, 32'd0);
        @(negedge clk);
        check("rd2_done", {30'd0, io_req_ready, io_rsp_valid}, 32'd2);

        // Latch and read-back control words
        for (int i = 0; i < 3; i++) begin
            io_req_valid = 1'b1; io_req_we = 1'b1; io_req_addr = 2'd3; io_req_data = ctl_v[i];
            @(negedge clk);
            io_req_valid = 1'b0;
            check($sformatf("ctl_%0h", ctl_v[i]), {17'd0, strobes}, {17'd0, ctl_e[i]});
            @(negedge clk);
        end

        // Read-back with empty mask produces nothing
        io_req_valid = 1'b1; io_req_we = 1'b1; io_req_addr = 2'd3; io_req_data = 8'hC0;
        @(negedge clk);
        io_req_valid = 1'b0;
        check("rb_mask0", {17'd0, strobes}, 32'd0);

        // Control port read returns 0xFF without a strobe
        io_req_valid = 1'b1; io_req_we = 1'b0; io_req_addr = 2'd3;
        @(negedge clk);
        io_req_valid = 1'b0;
        check("rd3_no_strobe", {17'd0, strobes}, 32'd0);
        @(negedge clk);
        check("rd3_rsp", {23'd0, io_rsp_valid, io_rsp_data}, {23'd0, 1'b1, 8'hFF});
        @(negedge clk);

        // Reset during a pending read drops the response
        io_req_valid = 1'b1; io_req_we = 1'b0; io_req_addr = 2'd1;
        @(negedge clk);
        io_req_valid = 1'b0;
        check("rr_strobe", {17'd0, strobes}, {17'd0, 15'b000_000_000_000_010});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rr_rsp", {23'd0, io_rsp_valid, io_rsp_data}, 32'd0);
        check("rr_strobes", {17'd0, strobes}, 32'd0);
        check("rr_ready", {31'd0, io_req_ready}, 32'd1);
        @(negedge clk);
        check("rr_no_late_rsp", {28'd0, io_rsp_valid, cnt_read}, 32'd0);

        // Gate synchroniser: two-cycle lag
        gate_in = 3'b101;
        @(posedge clk); #1;
        check("gate_lag1", {29'd0, cnt_gate}, 32'd0);
        @(posedge clk); #1;
        check("gate_lag2", {29'd0, cnt_gate}, 32'b101);

        // 50000 clk cycles at 100 MHz -> 596.59 PIT periods
        edges    = 0;
        pit_prev = pit_clock;
        for (int c = 0; c < 50000; c++) begin
            @(negedge clk);
            if (pit_clock && !pit_prev) edges++;
            pit_prev = pit_clock;
        end
        check("pit_edges", {31'd0, (edges >= 596 && edges <= 597)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pit_8254_bus_if.md
Name: pit_8254_bus_if

Overview:
- Upstream front end for the three pit_8254_counter instances of the PIT.
- Accepts 8-bit I/O requests on a valid/ready bus for port offsets 0..3 (0x40-0x43).
- Decodes 8254 control words: mode set, counter latch and read-back. Produces per-channel one-cycle strobes and a broadcast data byte, and returns read data.
- Generates the ~1.193182 MHz PIT clock from the system clock with a fractional phase accumulator, and synchronises the three gate inputs.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- PIT_FREQ_HZ, 1193182, target PIT input clock frequency.
- ACC_W, 32, phase accumulator width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_req_valid  in  1  request valid
- io_req_ready  out  1  request accepted when valid&&ready
- io_req_addr  in  2  port offset (0..2 = counter 0..2, 3 = control)
- io_req_we  in  1  1 = write, 0 = read
- io_req_data  in  8  write data
- io_rsp_valid  out  1  one-cycle read response pulse
- io_rsp_data  out  8  read data, valid with io_rsp_valid
- gate_in  in  3  asynchronous gate inputs for ch2..ch0
- pit_clock  out  1  shared counter clock input
- cnt_gate  out  3  synchronised gates for ch2..ch0
- cnt_data_in  out  8  broadcast data byte for all counters
- cnt_set_control_mode  out  3  per-channel strobe
- cnt_latch_count  out  3  per-channel strobe
- cnt_latch_status  out  3  per-channel strobe
- cnt_write  out  3  per-channel strobe
- cnt_read  out  3  per-channel strobe
- cnt_data_out  in  24  counter data outputs {ch2,ch1,ch0}

Behaviour:
- Reset values: all strobes 0, cnt_data_in 0, io_rsp_valid 0, io_rsp_data 0, pit_clock 0, accumulator 0, cnt_gate 0. io_req_ready is 0 while reset is high.
- io_req_ready = ~reset & ~rd_busy.
- Write latency:
  - Request accepted in cycle N.
  - In cycle N+1 exactly one strobe group is active for one cycle, and cnt_data_in = the accepted data.
  - Writes produce no response.
  - Back-to-back writes are accepted every cycle.
- Write to addr 0..2: cnt_write[addr] = 1.
- Write to addr 3 with SC = data[7:6] != 3:
  - If RW = data[5:4] == 0: cnt_latch_count[SC] = 1 (counter latch command). No set_control_mode.
  - Otherwise: cnt_set_control_mode[SC] = 1.
- Write to addr 3 with SC == 3 (read-back):
  - mask = data[3:1] (bit k selects ch k).
  - cnt_latch_count = mask if data[5] == 0, else 0.
  - cnt_latch_status = mask if data[4] == 0, else 0.
  - Both strobe groups fire in the same cycle. A mask of 0 produces no strobes.
- Read from addr 0..2:
  - rd_busy is set at acceptance (cycle N).
  - In cycle N+1: cnt_read[addr] = 1, and io_rsp_data captures cnt_data_out[8*addr+:8] in the same cycle, i.e. pre-update value, since the counter advances msb/status state on the strobe.
  - In cycle N+2: io_rsp_valid = 1 and rd_busy clears. The next request can be accepted in N+3.
- Read from addr 3: no strobe. Response follows the same timing with io_rsp_data = 0xFF.
- Phase accumulator:
  - INC = round(PIT_FREQ_HZ * 2^ACC_W / CLK_FREQ_HZ); acc <= acc + INC each cycle, wrapping modulo 2^ACC_W.
  - pit_clock = registered acc[ACC_W-1].
  - Elaboration assertion: 2*PIT_FREQ_HZ <= CLK_FREQ_HZ, so each pit_clock level lasts at least 1 clk.
- Gates: 2-flop synchroniser per bit; cnt_gate lags gate_in by 2 cycles.
- Reset mid-read: the pending response is dropped. No io_rsp_valid or cnt_read follows.
- Reset mid-write: the pending strobe is dropped.
- Simultaneous events: only one request is accepted per cycle, so at most one command is decoded per cycle. The accumulator and gate synchroniser run independently of bus traffic.

Decomposition:
- Package pit_8254_pkg holds:
  - port offsets PIT_PORT_CNT0..PIT_PORT_CTRL;
  - control word field positions (SC, RW, MODE, BCD);
  - constants RW_LATCH = 2'b00 and SC_READBACK = 2'b11;
  - read-back bit positions;
  - function pit_phase_inc(clk_hz, pit_hz, acc_w).
- Sub-module pit_8254_clkgen: phase accumulator, pit_clock register and gate synchroniser.

Test Plan:
- Write 0x34 to addr 3 -> in N+1 cnt_set_control_mode = 3'b001, cnt_data_in = 0x34, all other strobes 0, no io_rsp_valid.
- Writes 0x9C then 0x2E to addr 0 on consecutive cycles -> cnt_write = 3'b001 in two consecutive cycles, with cnt_data_in 0x9C then 0x2E. io_req_ready stays 1.
- Read addr 2 with cnt_data_out[23:16] = 0x5A, changing to 0x12 after the strobe -> cnt_read = 3'b100 in N+1, io_rsp_valid in N+2 with 0x5A, io_req_ready = 0 in N+1..N+2.
- Control writes 0x40, 0xC2 and 0xE6 -> respectively:
  - 0x40: cnt_latch_count = 3'b010 only;
  - 0xC2: cnt_latch_count = 3'b001 and cnt_latch_status = 3'b001 in the same cycle;
  - 0xE6: cnt_latch_status = 3'b011, cnt_latch_count = 0.
- With defaults, count pit_clock rising edges over 10^6 clk cycles -> 11931 or 11932. gate_in step 0->1 -> cnt_gate rises exactly 2 cycles later.
- Read addr 1 accepted, reset asserted in N+1 for one cycle -> no io_rsp_valid, outputs at reset values, io_req_ready = 1 the cycle after reset drops.
